cc_miss_request_unit: RTL and testbench
=======================================

Name: cc_miss_request_unit

Overview:
Upstream neighbour of the cache-controller data fill stage. Accepts cache-miss requests from the tag-compare stage and issues one AXI AR burst per miss (8 x 64-bit, WRAP, critical word first). In the same cycle it pushes the full miss address into the miss-address FIFO, which the fill stage pops on the first R beat. It bounds in-flight line fills with an outstanding counter that is retired on the R-channel last beat.

Parameters:
ADDR_W, 32, byte address width
MAX_OUTSTANDING, 4, maximum line fills in flight (AR issued, RLAST not yet seen); must be >= 1
BURST_BEATS, 8, beats per line fill (64 B line / 8 B beat); ARLEN = BURST_BEATS-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
miss_valid_i  in  1  miss request valid
miss_addr_i  in  ADDR_W  byte address of the missing word
miss_ready_o  out  1  miss request accepted when valid&ready
mem_arvalid_o  out  1  AXI AR valid
mem_arready_i  in  1  AXI AR ready
mem_araddr_o  out  ADDR_W  AR address, 8-byte aligned
mem_arlen_o  out  4  constant BURST_BEATS-1 (7)
mem_arsize_o  out  3  constant 3'd3 (8 B)
mem_arburst_o  out  2  constant 2'b10 (WRAP)
mem_arid_o  out  4  constant 0
mem_rvalid_i  in  1  R valid (monitor only)
mem_rready_i  in  1  R ready (monitor only)
mem_rlast_i  in  1  R last (monitor only)
miss_addr_fifo_full_i  in  1  miss-address FIFO full
miss_addr_fifo_wren_o  out  1  FIFO push strobe
miss_addr_fifo_wdata_o  out  ADDR_W  full miss address (tag/index/offset intact)
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, mem_arvalid_o=0, mem_araddr_o=0, outstanding=0, miss_ready_o=0 in the reset cycle, miss_addr_fifo_wren_o=0. Reset mid-burst drops ARVALID immediately. R beats already in flight are not tracked after reset.
- States: IDLE, REQ.
- IDLE: miss_ready_o = !miss_addr_fifo_full_i & (outstanding < MAX_OUTSTANDING). This is combinational, and miss_valid_i does not feed into it.
- Accept (IDLE & miss_valid_i & miss_ready_o):
  - miss_addr_fifo_wren_o=1 in the same cycle (combinational), wdata=miss_addr_i.
  - Register araddr={miss_addr_i[ADDR_W-1:3],3'b000}.
  - Next state REQ.
- REQ: mem_arvalid_o=1 (registered), miss_ready_o=0. ARADDR is held stable until the handshake. ARVALID never drops without ARREADY. On arvalid&arready, next state is IDLE and ARVALID=0 the next cycle.
- Latency: accept at cycle N gives ARVALID high from N+1. Minimum two cycles per miss (no back-to-back accept in REQ).
- FIFO ordering: the push happens at accept, strictly before the AR handshake. The FIFO entry is therefore present before any R beat for that burst.
- Outstanding counter:
  - inc = AR handshake; dec = mem_rvalid_i & mem_rready_i & mem_rlast_i.
  - Both in the same cycle: unchanged. inc only: +1. dec only: -1.
  - dec at 0 is a protocol error: saturate at 0; a simulation assertion fires.
  - inc at MAX_OUTSTANDING is unreachable by construction: acceptance is blocked at MAX, and the counter cannot change between accept and AR handshake except downward.
- miss_ready_o reflects the current count. An RLAST in the same cycle does not open acceptance until the next cycle.
- FIFO full while in REQ: no effect on the pending AR, since the push is already done.
- miss_valid_i dropping while miss_ready_o=0 is legal and ignored. An accepted request is never retracted.
- Constant AR fields are driven at all times, including reset.

Decomposition:
- Shared package cc_pkg holds:
  - constants LINE_BYTES=64, BEAT_BYTES=8, AXI_BURST_WRAP=2'b10, AXI_SIZE_8B=3'd3
  - address field widths TAG_W=17, INDEX_W=9, OFFSET_W=6
  - typedef enum logic {S_IDLE, S_REQ} miss_req_state_t
- Natural sub-module: cc_outstanding_counter. This is a parameterised up/down counter with simultaneous inc/dec, saturation and a full flag. Everything else stays in one module.

Test Plan:
- Single miss: miss_valid_i=1, addr 0x0001_2358, FIFO empty, arready tied 1:
  - accept cycle: FIFO push wdata=0x0001_2358.
  - next cycle: ARVALID=1, ARADDR=0x0001_2358, ARLEN=7, ARBURST=2'b10.
  - outstanding=1.
  - 8 R beats with RLAST on the 8th: outstanding returns to 0.
- AR backpressure: arready=0 for 5 cycles after ARVALID. ARVALID and ARADDR stay stable, miss_ready_o=0 and no further FIFO pushes for all 5 cycles. Handshake on cycle 6.
- Outstanding limit: 4 misses with no R traffic. 5th miss_valid_i sees miss_ready_o=0. A single RLAST beat re-enables acceptance on the next cycle; outstanding goes 4 -> 3 -> 4.
- Simultaneous inc/dec: at outstanding=2, AR handshake and RLAST beat in the same cycle -> outstanding stays 2.
- FIFO full: miss_addr_fifo_full_i=1 with miss_valid_i=1 -> no push, no AR, miss_ready_o=0. Deassert full -> accept next cycle.
- Reset mid-operation: rst=1 while in REQ with ARVALID=1, outstanding=3 -> next cycle ARVALID=0, outstanding=0, state IDLE, no FIFO push.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller constants, address field widths and miss-request FSM states.
// No logic; parameters only.
// Imported by the miss-request unit and its outstanding counter.
package cc_pkg;

    localparam int LINE_BYTES = 64;
    localparam int BEAT_BYTES = 8;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

    // Address split for a 32-bit byte address: tag | index | line offset
    localparam int TAG_W    = 17;
    localparam int INDEX_W  = 9;
    localparam int OFFSET_W = 6;

    typedef enum logic {S_IDLE, S_REQ} miss_req_state_t;

endpackage

// File: rtl/cc_outstanding_counter.sv
// Up/down in-flight counter with simultaneous inc/dec, saturation at 0 and MAX, and a full flag.
// Latency: count updates one cycle after inc/dec; full is combinational from the registered count.
// Backpressure: none internally; callers use full to stop issuing new increments.
module cc_outstanding_counter
    import cc_pkg::*;
#(
    parameter int MAX = 4,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);

    assign full = (count == W'(MAX));

    // Net change only when exactly one of inc/dec is active; clamp at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && count != W'(MAX)) begin
            count <= count + W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - W'(1);
        end
    end

    // A retire with nothing in flight means the memory side returned an unrequested RLAST
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dec && !inc && count == '0))
                else $error("cc_outstanding_counter: RLAST retire with zero outstanding");
        end
    end

endmodule

// File: rtl/cc_miss_request_unit.sv
// Turns accepted cache misses into one AXI AR WRAP burst each, pushing the full miss address to the fill FIFO.
// Latency: accept in cycle N (FIFO push same cycle), ARVALID from N+1; at least two cycles per miss.
// Backpressure: miss_ready_o low while an AR is pending, the miss FIFO is full or MAX_OUTSTANDING fills are in flight.
module cc_miss_request_unit
    import cc_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_BEATS     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   miss_valid_i,
    input  logic [ADDR_W-1:0]                      miss_addr_i,
    output logic                                   miss_ready_o,
    output logic                                   mem_arvalid_o,
    input  logic                                   mem_arready_i,
    output logic [ADDR_W-1:0]                      mem_araddr_o,
    output logic [3:0]                             mem_arlen_o,
    output logic [2:0]                             mem_arsize_o,
    output logic [1:0]                             mem_arburst_o,
    output logic [3:0]                             mem_arid_o,
    input  logic                                   mem_rvalid_i,
    input  logic                                   mem_rready_i,
    input  logic                                   mem_rlast_i,
    input  logic                                   miss_addr_fifo_full_i,
    output logic                                   miss_addr_fifo_wren_o,
    output logic [ADDR_W-1:0]                      miss_addr_fifo_wdata_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    miss_req_state_t state;
    logic            ost_full;
    logic            accept;
    logic            ar_hs;
    logic            r_retire;

    // Fixed burst shape: whole line, 8-byte beats, wrapping so the critical word comes first
    assign mem_arlen_o   = 4'(BURST_BEATS - 1);
    assign mem_arsize_o  = AXI_SIZE_8B;
    assign mem_arburst_o = AXI_BURST_WRAP;
    assign mem_arid_o    = 4'd0;

    // Ready ignores miss_valid_i; the reset term keeps the reset cycle from accepting
    assign miss_ready_o = !rst && (state == S_IDLE) && !miss_addr_fifo_full_i && !ost_full;
    assign accept       = miss_valid_i && miss_ready_o;

    // The FIFO push happens at accept, so the entry always precedes every R beat of its burst
    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = miss_addr_i;

    assign ar_hs    = mem_arvalid_o && mem_arready_i;
    assign r_retire = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    // Two-state request FSM; ARVALID/ARADDR are registered and held until the AR handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mem_arvalid_o <= 1'b0;
            mem_araddr_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state         <= S_REQ;
                        mem_arvalid_o <= 1'b1;
                        mem_araddr_o  <= {miss_addr_i[ADDR_W-1:3], 3'b000};
                    end
                end
                S_REQ: begin
                    if (mem_arready_i) begin
                        state         <= S_IDLE;
                        mem_arvalid_o <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    mem_arvalid_o <= 1'b0;
                end
            endcase
        end
    end

    cc_outstanding_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk   (clk),
        .rst   (rst),
        .inc   (ar_hs),
        .dec   (r_retire),
        .count (outstanding_o),
        .full  (ost_full)
    );

endmodule

// File: tb/tb_cc_miss_request_unit.sv
// Self-checking bench for cc_miss_request_unit: vector table, directed corner sequences, random vs reference model.
// Inputs change 1 ns after the rising edge, outputs are checked 2 ns after it.
// Ends with a single summary line.
module tb_cc_miss_request_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid_i;
    logic [31:0] miss_addr_i;
    logic        miss_ready_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic [3:0]  mem_arid_o;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic [2:0]  outstanding_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cc_miss_request_unit #(
        .ADDR_W(32), .MAX_OUTSTANDING(4), .BURST_BEATS(8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .miss_valid_i           (miss_valid_i),
        .miss_addr_i            (miss_addr_i),
        .miss_ready_o           (miss_ready_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_arid_o             (mem_arid_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .outstanding_o          (outstanding_o)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] addr;
        logic        arready;
        logic        rbeat;
        logic        rlast;
        logic        full;
        logic        exp_ready;
        logic        exp_wren;
        logic        exp_arvalid;
        logic [31:0] exp_araddr;
        logic [2:0]  exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic arr,
                         input logic rb, input logic rl, input logic f);
        rst = r; miss_valid_i = v; miss_addr_i = a; mem_arready_i = arr;
        mem_rvalid_i = rb; mem_rready_i = rb; mem_rlast_i = rl; miss_addr_fifo_full_i = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        idle();
    endtask

    // One miss with arready high: accept cycle then AR cycle
    task automatic miss(input string nm, input logic [31:0] a);
        drive(1'b0, 1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk({nm, "_wren"}, 32'(miss_addr_fifo_wren_o), 32'd1);
        step();
        idle();
        #1;
        chk({nm, "_arvalid"}, 32'(mem_arvalid_o), 32'd1);
        step();
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] a, input logic arr,
                                input logic rb, input logic rl,
                                input logic er, input logic ew, input logic eav,
                                input logic [31:0] ead, input logic [2:0] eo);
        vec_t t;
        t.rst = 1'b0; t.valid = v; t.addr = a; t.arready = arr; t.rbeat = rb; t.rlast = rl;
        t.full = 1'b0; t.exp_ready = er; t.exp_wren = ew; t.exp_arvalid = eav;
        t.exp_araddr = ead; t.exp_out = eo;
        return t;
    endfunction

    // Reference model state: a pending AR (address) and the number of fills in flight
    bit          m_pend;
    logic [31:0] m_araddr;
    int          m_cnt;

    initial begin
        idle();

        // ---------------- reset state ----------------
        drive(1'b1, 1'b1, 32'h0001_2358, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        #1;
        chk("rst_ready", 32'(miss_ready_o), 32'd0);
        chk("rst_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
        chk("rst_arvalid", 32'(mem_arvalid_o), 32'd0);
        chk("rst_araddr", mem_araddr_o, 32'd0);
        chk("rst_out", 32'(outstanding_o), 32'd0);
        chk("c_arlen", 32'(mem_arlen_o), 32'd7);
        chk("c_arsize", 32'(mem_arsize_o), 32'd3);
        chk("c_arburst", 32'(mem_arburst_o), 32'd2);
        chk("c_arid", 32'(mem_arid_o), 32'd0);
        step();

        // ---------------- vector table: single miss + AR backpressure ----------------
        vecs.push_back(mk(1, 32'h0001_2358, 1, 0, 0, 1, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 0, 1, 32'h0001_2358, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 32'h0, 1, 1, 0, 1, 0, 0, 32'h0001_2358, 1));
        vecs.push_back(mk(0, 32'h0,         1, 1, 1, 1, 0, 0, 32'h0001_2358, 1));
        vecs.push_back(mk(1, 32'h0000_ABCC, 0, 0, 0, 1, 1, 0, 32'h0001_2358, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 32'h0005_5550, 0, 0, 0, 0, 0, 1, 32'h0000_ABC8, 0));
        vecs.push_back(mk(1, 32'h0005_5550, 1, 0, 0, 0, 0, 1, 32'h0000_ABC8, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0000_ABC8, 1));
        vecs.push_back(mk(0, 32'h0,         1, 1, 1, 1, 0, 0, 32'h0000_ABC8, 1));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0000_ABC8, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].addr, vecs[i].arready,
                  vecs[i].rbeat, vecs[i].rlast, vecs[i].full);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(miss_ready_o), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_wren", i), 32'(miss_addr_fifo_wren_o), 32'(vecs[i].exp_wren));
            if (vecs[i].exp_wren)
                chk($sformatf("v%0d_wdata", i), miss_addr_fifo_wdata_o, vecs[i].addr);
            chk($sformatf("v%0d_arvalid", i), 32'(mem_arvalid_o), 32'(vecs[i].exp_arvalid));
            chk($sformatf("v%0d_araddr", i), mem_araddr_o, vecs[i].exp_araddr);
            chk($sformatf("v%0d_out", i), 32'(outstanding_o), 32'(vecs[i].exp_out));
            chk($sformatf("v%0d_arlen", i), 32'(mem_arlen_o), 32'd7);
            step();
        end

        // ---------------- outstanding limit ----------------
        do_reset();
        for (int i = 0; i < 4; i++) miss($sformatf("lim%0d", i), 32'h1000_0000 + 32'(i * 64));
        drive(1'b0, 1'b1, 32'h2000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lim_out4", 32'(outstanding_o), 32'd4);
        chk("lim_ready0", 32'(miss_ready_o), 32'd0);
        chk("lim_wren0", 32'(miss_addr_fifo_wren_o), 32'd0);
        step();
        drive(1'b0, 1'b1, 32'h2000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lim_rlast_ready0", 32'(miss_ready_o), 32'd0);
        chk("lim_rlast_out4", 32'(outstanding_o), 32'd4);
        step();
        drive(1'b0, 1'b1, 32'h2000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lim_out3", 32'(outstanding_o), 32'd3);
        chk("lim_reopen_wren", 32'(miss_addr_fifo_wren_o), 32'd1);
        step();
        idle();
        #1;
        chk("lim_ar_araddr", mem_araddr_o, 32'h2000_0000);
        step();
        #1;
        chk("lim_back4", 32'(outstanding_o), 32'd4);

        // ---------------- simultaneous inc/dec ----------------
        do_reset();
        miss("sim0", 32'h0000_0100);
        miss("sim1", 32'h0000_0200);
        drive(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sim_out2", 32'(outstanding_o), 32'd2);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("sim_arvalid", 32'(mem_arvalid_o), 32'd1);
        step();
        idle();
        #1;
        chk("sim_out_stays2", 32'(outstanding_o), 32'd2);

        // ---------------- FIFO full ----------------
        do_reset();
        drive(1'b0, 1'b1, 32'h0000_7770, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("full_ready0", 32'(miss_ready_o), 32'd0);
        chk("full_wren0", 32'(miss_addr_fifo_wren_o), 32'd0);
        step();
        drive(1'b0, 1'b1, 32'h0000_7770, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_noar", 32'(mem_arvalid_o), 32'd0);
        chk("full_clear_wren", 32'(miss_addr_fifo_wren_o), 32'd1);
        step();
        idle();
        #1;
        chk("full_ar", 32'(mem_arvalid_o), 32'd1);
        step();

        // ---------------- reset mid-operation ----------------
        do_reset();
        for (int i = 0; i < 3; i++) miss($sformatf("mr%0d", i), 32'h3000_0000 + 32'(i * 64));
        drive(1'b0, 1'b1, 32'h3000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h3000_2000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mr_pre_arvalid", 32'(mem_arvalid_o), 32'd1);
        chk("mr_pre_out3", 32'(outstanding_o), 32'd3);
        chk("mr_rst_wren0", 32'(miss_addr_fifo_wren_o), 32'd0);
        step();
        idle();
        miss_valid_i = 1'b0;
        #1;
        chk("mr_arvalid0", 32'(mem_arvalid_o), 32'd0);
        chk("mr_out0", 32'(outstanding_o), 32'd0);
        chk("mr_araddr0", mem_araddr_o, 32'd0);
        chk("mr_idle_ready", 32'(miss_ready_o), 32'd1);
        step();

        // ---------------- random vs reference model ----------------
        do_reset();
        m_pend = 1'b0; m_araddr = 32'h0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, v, arr, rb, rl, f, e_ready, e_wren, hs;
            logic [31:0] a;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            arr = ($urandom_range(0, 2) != 0);
            rb  = ($urandom_range(0, 1) == 1);
            rl  = rb && (m_cnt > 0) && ($urandom_range(0, 5) == 0);
            f   = ($urandom_range(0, 7) == 0);
            drive(r, v, a, arr, rb, rl, f);
            #1;
            e_ready = !r && !m_pend && !f && (m_cnt < 4);
            e_wren  = v && e_ready;
            chk("rnd_ready", 32'(miss_ready_o), 32'(e_ready));
            chk("rnd_wren", 32'(miss_addr_fifo_wren_o), 32'(e_wren));
            if (e_wren) chk("rnd_wdata", miss_addr_fifo_wdata_o, a);
            chk("rnd_arvalid", 32'(mem_arvalid_o), 32'(m_pend));
            chk("rnd_araddr", mem_araddr_o, m_araddr);
            chk("rnd_out", 32'(outstanding_o), 32'(m_cnt));
            if (r) begin
                m_pend = 1'b0; m_araddr = 32'h0; m_cnt = 0;
            end else begin
                hs = m_pend && arr;
                m_cnt = m_cnt + (hs ? 1 : 0) - (rl ? 1 : 0);
                if (e_wren) begin
                    m_pend = 1'b1;
                    m_araddr = a & 32'hFFFF_FFF8;
                end else if (hs) begin
                    m_pend = 1'b0;
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
